// File: rtl/dyn_branch_predictor_if.sv
// Fetch/decode-side signal bundle for dyn_branch_predictor: fetch read port plus decode-stage update port.
interface dyn_branch_predictor_if #(
    parameter int unsigned PC_W = 16
);
    logic [PC_W-1:0] PC_curr;
    logic [PC_W-1:0] IF_ID_PC_curr;
    logic [1:0]      IF_ID_prediction;
    logic            enable;
    logic            was_branch;
    logic            actual_taken;
    logic [PC_W-1:0] actual_target;
    logic            branch_mispredicted;
    logic [1:0]      prediction;
    logic [PC_W-1:0] predicted_target;

    modport master (
        output PC_curr, IF_ID_PC_curr, IF_ID_prediction, enable, was_branch,
               actual_taken, actual_target, branch_mispredicted,
        input  prediction, predicted_target
    );

    modport slave (
        input  PC_curr, IF_ID_PC_curr, IF_ID_prediction, enable, was_branch,
               actual_taken, actual_target, branch_mispredicted,
        output prediction, predicted_target
    );
endinterface

// File: rtl/dyn_branch_predictor.sv
// Direct-mapped 2-bit BHT + BTB branch predictor; combinational fetch read, decode-stage update.
// Optional macro DBP_BTB_TAG_EN adds BTB tags so aliased PCs miss instead of sharing an entry.
module dyn_branch_predictor #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned PC_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    dyn_branch_predictor_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [1:0]       bht        [DEPTH];
    logic [PC_W-1:0]  btb_target [DEPTH];
    logic [DEPTH-1:0] btb_valid;
`ifdef DBP_BTB_TAG_EN
    localparam int unsigned TAG_W = PC_W - IDX_W - 1;
    logic [TAG_W-1:0] btb_tag    [DEPTH];
`endif

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] u_idx;
    logic             bht_we;
    logic             btb_we;
    logic [1:0]       next_ctr;
    logic             unused_pc_bits;

    assign r_idx  = bus.PC_curr[IDX_W:1];
    assign u_idx  = bus.IF_ID_PC_curr[IDX_W:1];
    assign bht_we = bus.enable & bus.was_branch;
    assign btb_we = bht_we & bus.actual_taken & bus.branch_mispredicted;

    // Halfword bit and (untagged) upper PC bits do not take part in indexing.
    assign unused_pc_bits = ^{bus.PC_curr[0], bus.PC_curr[PC_W-1:IDX_W+1],
                              bus.IF_ID_PC_curr[0], bus.IF_ID_PC_curr[PC_W-1:IDX_W+1]};

    // Counter update uses the prediction carried down the pipe, not a table re-read.
    always_comb begin
        next_ctr = bus.IF_ID_prediction;
        if (bus.actual_taken) begin
            if (bus.IF_ID_prediction != 2'b11) next_ctr = bus.IF_ID_prediction + 2'b01;
        end else begin
            if (bus.IF_ID_prediction != 2'b00) next_ctr = bus.IF_ID_prediction - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bht[i]        <= '0;
                btb_target[i] <= '0;
`ifdef DBP_BTB_TAG_EN
                btb_tag[i]    <= '0;
`endif
            end
            btb_valid <= '0;
        end else begin
            if (bht_we) bht[u_idx] <= next_ctr;
            if (btb_we) begin
                btb_target[u_idx] <= bus.actual_target;
                btb_valid[u_idx]  <= 1'b1;
`ifdef DBP_BTB_TAG_EN
                btb_tag[u_idx]    <= bus.IF_ID_PC_curr[PC_W-1:IDX_W+1];
`endif
            end
        end
    end

    always_comb begin
        bus.prediction       = bht[r_idx];
        bus.predicted_target = btb_valid[r_idx] ? btb_target[r_idx] : '0;
`ifdef DBP_BTB_TAG_EN
        if (!(btb_valid[r_idx] && (btb_tag[r_idx] == bus.PC_curr[PC_W-1:IDX_W+1]))) begin
            bus.prediction       = 2'b00;
            bus.predicted_target = '0;
        end
`endif
    end
endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed self-checking bench for dyn_branch_predictor (default and DBP_BTB_TAG_EN builds).
module tb_dyn_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dyn_branch_predictor_if #(.PC_W(16)) bus ();

    dyn_branch_predictor #(.IDX_W(3), .PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [15:0] pc,
                            input logic [1:0] exp_pred, input logic [15:0] exp_tgt);
        bus.PC_curr = pc;
        #1;
        chk({tag, "_pred"}, {14'd0, bus.prediction}, {14'd0, exp_pred});
        chk({tag, "_tgt"}, bus.predicted_target, exp_tgt);
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic [1:0] pred, input logic taken,
                             input logic [15:0] tgt, input logic misp);
        bus.IF_ID_PC_curr       = pc;
        bus.IF_ID_prediction    = pred;
        bus.enable              = 1'b1;
        bus.was_branch          = 1'b1;
        bus.actual_taken        = taken;
        bus.actual_target       = tgt;
        bus.branch_mispredicted = misp;
    endtask

    task automatic edge_idle();
        @(posedge clk);
        #1;
        bus.enable     = 1'b0;
        bus.was_branch = 1'b0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic [1:0] pred, input logic taken,
                       input logic [15:0] tgt, input logic misp);
        drive_upd(pc, pred, taken, tgt, misp);
        edge_idle();
    endtask

    initial begin
        bus.PC_curr             = '0;
        bus.IF_ID_PC_curr       = '0;
        bus.IF_ID_prediction    = '0;
        bus.enable              = 1'b0;
        bus.was_branch          = 1'b0;
        bus.actual_taken        = 1'b0;
        bus.actual_target       = '0;
        bus.branch_mispredicted = 1'b0;

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_chk("reset", 16'h0008, 2'b00, 16'h0000);

        upd(16'h0008, 2'b00, 1'b1, 16'h0080, 1'b1);
        read_chk("taken1", 16'h0008, 2'b01, 16'h0080);
        upd(16'h0008, 2'b01, 1'b1, 16'h0080, 1'b1);
        read_chk("taken2", 16'h0008, 2'b10, 16'h0080);

        // Non-branch with enable, then branch without enable: neither may write.
        drive_upd(16'h000A, 2'b00, 1'b1, 16'h0100, 1'b1);
        bus.was_branch = 1'b0;
        edge_idle();
        drive_upd(16'h000A, 2'b00, 1'b1, 16'h0100, 1'b1);
        bus.enable = 1'b0;
        edge_idle();
        read_chk("nobranch_a", 16'h000A, 2'b00, 16'h0000);
        read_chk("nobranch_8", 16'h0008, 2'b10, 16'h0080);

        upd(16'h0008, 2'b10, 1'b1, 16'h0080, 1'b0);
        read_chk("sat_11", 16'h0008, 2'b11, 16'h0080);
        upd(16'h0008, 2'b11, 1'b1, 16'h0080, 1'b0);
        read_chk("sat_hold", 16'h0008, 2'b11, 16'h0080);
        upd(16'h0008, 2'b11, 1'b0, 16'h0200, 1'b1);
        read_chk("nt_10", 16'h0008, 2'b10, 16'h0080);
        upd(16'h0008, 2'b10, 1'b0, 16'h0200, 1'b1);
        read_chk("nt_01", 16'h0008, 2'b01, 16'h0080);
        upd(16'h0008, 2'b00, 1'b0, 16'h0200, 1'b1);
        read_chk("nt_floor", 16'h0008, 2'b00, 16'h0080);

        // Table holds 00 at 0xC; carried-in 11 must saturate, not increment the table value.
        upd(16'h000C, 2'b11, 1'b1, 16'h0040, 1'b1);
        read_chk("from_ifid", 16'h000C, 2'b11, 16'h0040);

        // Same-cycle read/write of one index: old value before the edge, new after.
        bus.PC_curr = 16'h0008;
        drive_upd(16'h0008, 2'b00, 1'b1, 16'h0300, 1'b1);
        read_chk("same_old", 16'h0008, 2'b00, 16'h0080);
        edge_idle();
        read_chk("same_new", 16'h0008, 2'b01, 16'h0300);

        upd(16'h0008, 2'b01, 1'b1, 16'h0500, 1'b0);
        read_chk("nomisp_btb", 16'h0008, 2'b10, 16'h0300);

`ifdef DBP_BTB_TAG_EN
        read_chk("alias_18", 16'h0018, 2'b00, 16'h0000);
`else
        read_chk("alias_18", 16'h0018, 2'b10, 16'h0300);
`endif

        drive_upd(16'h0008, 2'b10, 1'b1, 16'h0700, 1'b1);
        rst = 1'b1;
        edge_idle();
        rst = 1'b0;
        read_chk("rst_prio_8", 16'h0008, 2'b00, 16'h0000);
        read_chk("rst_prio_c", 16'h000C, 2'b00, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
